// File: rtl/fb_read_responder_if.sv
// Word-wide framebuffer memory port: single-outstanding read request/response.
// master = responder side (issues requests), slave = memory side.
interface fb_read_responder_if #(
    parameter int unsigned MEM_AW = 21,
    parameter int unsigned WORD_W = 32
);
    logic              mem_req;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/fb_read_responder.sv
// Framebuffer read responder: serves 4-bit pixels from a current/prefetch word pair,
// refilling them from word memory with at most one read outstanding.
module fb_read_responder #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned MEM_AW = ADDR_W - 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    pix_addr,
    output logic [3:0]           pix_data,
    output logic                 pix_hit,
    fb_read_responder_if.master  mem
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    typedef enum logic {T_DEMAND, T_PREFETCH} tgt_t;

    state_t state_q, state_d;
    tgt_t   tgt_q, tgt_d;

    logic              mem_req_q, mem_req_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        pix_data_q, pix_data_d;
    logic              pix_hit_q, pix_hit_d;

    logic [MEM_AW-1:0] cur_tag_q, cur_tag_d, nxt_tag_q, nxt_tag_d;
    logic [WORD_W-1:0] cur_data_q, cur_data_d, nxt_data_q, nxt_data_d;
    logic              cur_valid_q, cur_valid_d, nxt_valid_q, nxt_valid_d;

    logic [MEM_AW-1:0] w;
    logic [2:0]        n;
    logic              hit_cur, hit_nxt, hit;
    logic [WORD_W-1:0] sel_word;
    logic              eff_cur_valid, eff_nxt_valid;
    logic [MEM_AW-1:0] eff_cur_tag, cur_succ;
    logic              need_demand, need_prefetch, need;
    logic              fill, fill_to_cur, fill_to_nxt;

    // Lookup and fetch-need evaluation; "eff" values reflect the buffers after any promotion.
    always_comb begin
        w             = pix_addr[ADDR_W-1:3];
        n             = pix_addr[2:0];
        hit_cur       = cur_valid_q && (cur_tag_q == w);
        hit_nxt       = !hit_cur && nxt_valid_q && (nxt_tag_q == w);
        hit           = hit_cur || hit_nxt;
        sel_word      = hit_cur ? cur_data_q : nxt_data_q;
        eff_cur_valid = cur_valid_q || hit_nxt;
        eff_cur_tag   = hit_nxt ? nxt_tag_q : cur_tag_q;
        eff_nxt_valid = nxt_valid_q && !hit_nxt;
        cur_succ      = eff_cur_tag + MEM_AW'(1);
        need_demand   = !hit;
        need_prefetch = eff_cur_valid && !(eff_nxt_valid && (nxt_tag_q == cur_succ));
        need          = need_demand || need_prefetch;
        fill          = (state_q == S_WAIT) && mem.mem_rvalid;
        fill_to_cur   = fill && ((mem_addr_q == w) || (tgt_q == T_DEMAND));
        fill_to_nxt   = fill && !fill_to_cur;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (need) state_d = S_REQ;
            S_REQ:   if (mem.mem_ready) state_d = S_WAIT;
            S_WAIT:  if (mem.mem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        tgt_d       = tgt_q;
        pix_hit_d   = hit;
        pix_data_d  = hit ? sel_word[{n, 2'b00} +: 4] : 4'h0;
        cur_tag_d   = cur_tag_q;
        cur_data_d  = cur_data_q;
        cur_valid_d = cur_valid_q;
        nxt_tag_d   = nxt_tag_q;
        nxt_data_d  = nxt_data_q;
        nxt_valid_d = nxt_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (need) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = need_demand ? w : cur_succ;
                    tgt_d      = need_demand ? T_DEMAND : T_PREFETCH;
                end
            end
            S_REQ:   if (mem.mem_ready) mem_req_d = 1'b0;
            default: ;
        endcase

        // Promotion owns CUR; a CUR-bound fill in the same cycle is dropped, an NXT fill overrides the clear.
        if (hit_nxt) begin
            cur_tag_d   = nxt_tag_q;
            cur_data_d  = nxt_data_q;
            cur_valid_d = 1'b1;
            nxt_valid_d = 1'b0;
        end else if (fill_to_cur) begin
            cur_tag_d   = mem_addr_q;
            cur_data_d  = mem.mem_rdata;
            cur_valid_d = 1'b1;
        end
        if (fill_to_nxt) begin
            nxt_tag_d   = mem_addr_q;
            nxt_data_d  = mem.mem_rdata;
            nxt_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q       <= T_DEMAND;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            pix_data_q  <= '0;
            pix_hit_q   <= 1'b0;
            cur_tag_q   <= '0;
            cur_data_q  <= '0;
            cur_valid_q <= 1'b0;
            nxt_tag_q   <= '0;
            nxt_data_q  <= '0;
            nxt_valid_q <= 1'b0;
        end else begin
            tgt_q       <= tgt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            pix_data_q  <= pix_data_d;
            pix_hit_q   <= pix_hit_d;
            cur_tag_q   <= cur_tag_d;
            cur_data_q  <= cur_data_d;
            cur_valid_q <= cur_valid_d;
            nxt_tag_q   <= nxt_tag_d;
            nxt_data_q  <= nxt_data_d;
            nxt_valid_q <= nxt_valid_d;
        end
    end

    assign pix_data     = pix_data_q;
    assign pix_hit      = pix_hit_q;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;

endmodule
